// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bit-serial adder controller: runs one full-adder cell over WIDTH bits, LSB first,
// with a start/busy/done handshake and registered sum/cout outputs.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, acc_reg, sum_reg;
  logic [WIDTH-1:0] acc_shifted;
  logic [CW-1:0]    cnt_reg;
  logic             c_reg, cout_reg, busy_reg, done_reg;
  logic             ha1_x, ha1_g, ha2_p, s0, cell_carry;

  // One-bit cell built as two cascaded half adders.
  assign ha1_x      = a_sh_reg[0] ^ b_sh_reg[0];
  assign ha1_g      = a_sh_reg[0] & b_sh_reg[0];
  assign s0         = ha1_x ^ c_reg;
  assign ha2_p      = ha1_x & c_reg;
  assign cell_carry = ha1_g | ha2_p;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_acc
      assign acc_shifted[gi] = acc_reg[gi+1];
    end
  endgenerate
  assign acc_shifted[WIDTH-1] = s0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg <= '0;
      b_sh_reg <= '0;
      acc_reg  <= '0;
      sum_reg  <= '0;
      cnt_reg  <= '0;
      c_reg    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg <= a;
            b_sh_reg <= b;
            c_reg    <= cin;
            cnt_reg  <= '0;
            acc_reg  <= '0;
          end
        end
        RUN: begin
          acc_reg  <= acc_shifted;
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          c_reg    <= cell_carry;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            sum_reg  <= acc_shifted;
            cout_reg <= cell_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. The one-bit cell is two cascaded half-adder stages: sum = a^b^c, carry = (a&b) | ((a^b)&c). The controller owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It sits between a requester that issues one add at a time and the shared adder cell. It replaces a WIDTH-bit ripple adder where area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge only
- b  input  WIDTH  operand B; captured on the accepting edge only
- cin  input  1  carry-in; captured on the accepting edge only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward
- sum  output  WIDTH  registered result; holds until the next completion
- cout  output  1  registered carry-out; holds until the next completion

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE, start=1:
  - load a_sh<=a, b_sh<=b, c<=cin, cnt<=0, acc<=0
  - go to RUN
- IDLE, start=0: stay in IDLE.
- RUN, every cycle:
  - compute s0 = a_sh[0]^b_sh[0]^c and the cell carry
  - acc <= {s0, acc[WIDTH-1:1]}
  - a_sh and b_sh shift right by one
  - c <= cell carry
  - cnt <= cnt+1
- RUN, when cnt==WIDTH-1:
  - sum <= {s0, acc[WIDTH-1:1]}
  - cout <= cell carry
  - go to DONE
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- The result is the mathematically exact a+b+cin mod 2^WIDTH. cout is bit WIDTH of the exact sum.
- cnt width is $clog2(WIDTH+1). There is no wrap-around inside RUN.
- start while busy=1 (RUN or DONE) is ignored. It is neither queued nor remembered.
- Operand inputs are don't-care except on the accepting edge.
- sum and cout change only on the RUN→DONE edge. They are never altered by a new start until that operation completes.
- WIDTH=1: RUN lasts a single cycle.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0
  - cnt=0, c=0
  - a_sh=0, b_sh=0, acc=0
- Reset release is synchronous to clk. start is first honoured on the first rising edge with rst_n=1.
- The accepting edge is E0. RUN occupies the cycles after E0..E(WIDTH-1). done=1 and the new sum/cout are visible in the cycle after edge EWIDTH.
- Latency from the accepting edge to the done cycle is WIDTH+1 clocks.
- Throughput is one operation per WIDTH+2 clocks:
  - the done cycle cannot accept
  - start held high in the cycle after done is accepted
- busy rises in the cycle after E0 and falls in the cycle after the done cycle.
- Reset asserted mid-RUN or in DONE:
  - the operation is abandoned
  - no done pulse
  - sum and cout read 0 afterwards
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x3C, b=0x5A, cin=0 → done exactly 9 clocks after the accepting edge, sum=0x96, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start pulsed every cycle during RUN with different operands → only the first operation is executed; exactly one done pulse; the result matches the first operands.
- rst_n driven low on the 4th RUN cycle of 0x12+0x34 → busy, done, sum and cout go 0 immediately; no done pulse; after release, 0x01+0x01 yields sum=0x02.
- start held high continuously → operations accepted back-to-back every 10 clocks; sum holds the previous value until each new done.
- WIDTH=1 build: a=1, b=1, cin=1 → sum=1, cout=1, done 2 clocks after acceptance. Random 1000-operation regression at WIDTH=8 and WIDTH=32, checked against a+b+cin.
